// File: rtl/ex_if.sv
// Bundle between decode/writeback and the execute stage: ID_EX in, MEM_WB
// writeback info in, branch redirect and registered EX_MEM out.
interface ex_if;
    logic [229:0] ID_EX;
    logic         MEM_WB_RegWrite;
    logic [4:0]   MEM_WB_WriteReg;
    logic [31:0]  MEM_WB_RegWriteData;
    logic         BranchTaken;
    logic [31:0]  branch_target;
    logic [105:0] EX_MEM;

    modport master (
        output ID_EX, MEM_WB_RegWrite, MEM_WB_WriteReg, MEM_WB_RegWriteData,
        input  BranchTaken, branch_target, EX_MEM
    );

    modport slave (
        input  ID_EX, MEM_WB_RegWrite, MEM_WB_WriteReg, MEM_WB_RegWriteData,
        output BranchTaken, branch_target, EX_MEM
    );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, branch resolution and the
// EX/MEM pipeline register.
module ex_stage (
    input  logic clk,
    input  logic reset,
    ex_if.slave  bus
);
    localparam logic [5:0] F_ADD  = 6'b000000;
    localparam logic [5:0] F_SUB  = 6'b000001;
    localparam logic [5:0] F_AND  = 6'b011000;
    localparam logic [5:0] F_OR   = 6'b011110;
    localparam logic [5:0] F_XOR  = 6'b010110;
    localparam logic [5:0] F_NOR  = 6'b010001;
    localparam logic [5:0] F_PASS = 6'b011010;
    localparam logic [5:0] F_SLL  = 6'b100000;
    localparam logic [5:0] F_SRL  = 6'b100001;
    localparam logic [5:0] F_SRA  = 6'b100011;
    localparam logic [5:0] F_EQ   = 6'b110011;
    localparam logic [5:0] F_NEQ  = 6'b110001;
    localparam logic [5:0] F_LT   = 6'b110101;
    localparam logic [5:0] F_LEZ  = 6'b111101;
    localparam logic [5:0] F_LTZ  = 6'b111011;
    localparam logic [5:0] F_GTZ  = 6'b111111;

    logic [31:0]  rs_data_s, rt_data_s, lu_data_s, pc_plus4_s, imm32_s;
    logic [4:0]   rs_s, rt_s, rd_s, shamt_s;
    logic         alu_src1_s, alu_src2_s, sign_s, mem_read_s, mem_write_s;
    logic         reg_write_s, lu_op_s, branch_s;
    logic [5:0]   alu_fun_s;
    logic [1:0]   mem_to_reg_s, reg_dst_s;

    logic [105:0] ex_mem_r;
    logic [105:0] ex_mem_next_s;
    logic [31:0]  fwd_rs_s, fwd_rt_s, op_a_s, op_b_s, alu_s, result_s;
    logic [4:0]   write_reg_s;
    logic         lt_s;

    assign rs_data_s    = bus.ID_EX[31:0];
    assign rt_data_s    = bus.ID_EX[63:32];
    assign rs_s         = bus.ID_EX[68:64];
    assign rt_s         = bus.ID_EX[73:69];
    assign rd_s         = bus.ID_EX[78:74];
    assign sign_s       = bus.ID_EX[79];
    assign alu_fun_s    = bus.ID_EX[85:80];
    assign alu_src2_s   = bus.ID_EX[86];
    assign alu_src1_s   = bus.ID_EX[87];
    assign mem_write_s  = bus.ID_EX[120];
    assign mem_read_s   = bus.ID_EX[121];
    assign reg_write_s  = bus.ID_EX[122];
    assign mem_to_reg_s = bus.ID_EX[124:123];
    assign lu_data_s    = bus.ID_EX[156:125];
    assign lu_op_s      = bus.ID_EX[157];
    assign pc_plus4_s   = bus.ID_EX[189:158];
    assign shamt_s      = bus.ID_EX[194:190];
    assign imm32_s      = bus.ID_EX[226:195];
    assign branch_s     = bus.ID_EX[227];
    assign reg_dst_s    = bus.ID_EX[229:228];

    // Loads in EX/MEM never forward; their data is not ready yet and the
    // decode stage has already inserted a bubble for the dependent op.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  src,
        input logic [31:0] reg_data,
        input logic        em_we,
        input logic        em_mr,
        input logic [1:0]  em_m2r,
        input logic [4:0]  em_reg,
        input logic [31:0] em_pc4,
        input logic [31:0] em_alu,
        input logic        wb_we,
        input logic [4:0]  wb_reg,
        input logic [31:0] wb_data
    );
        logic [31:0] r;
        r = reg_data;
        if (src == 5'd0) begin
            r = reg_data;
        end else if (em_we && !em_mr && (em_reg == src)) begin
            r = (em_m2r == 2'b10) ? em_pc4 : em_alu;
        end else if (wb_we && (wb_reg == src)) begin
            r = wb_data;
        end else begin
            r = reg_data;
        end
        return r;
    endfunction

    // Forwarded register operands and ALU input muxes
    always_comb begin
        fwd_rs_s = fwd_sel(rs_s, rs_data_s, ex_mem_r[105], ex_mem_r[102],
                           ex_mem_r[104:103], ex_mem_r[68:64], ex_mem_r[100:69],
                           ex_mem_r[31:0], bus.MEM_WB_RegWrite,
                           bus.MEM_WB_WriteReg, bus.MEM_WB_RegWriteData);
        fwd_rt_s = fwd_sel(rt_s, rt_data_s, ex_mem_r[105], ex_mem_r[102],
                           ex_mem_r[104:103], ex_mem_r[68:64], ex_mem_r[100:69],
                           ex_mem_r[31:0], bus.MEM_WB_RegWrite,
                           bus.MEM_WB_WriteReg, bus.MEM_WB_RegWriteData);
        op_a_s = alu_src1_s ? {27'd0, shamt_s} : fwd_rs_s;
        op_b_s = alu_src2_s ? imm32_s : fwd_rt_s;
    end

    // Less-than, signedness chosen per instruction
    always_comb begin
        lt_s = 1'b0;
        if (sign_s) begin
            lt_s = ($signed(op_a_s) < $signed(op_b_s));
        end else begin
            lt_s = (op_a_s < op_b_s);
        end
    end

    // ALU function decode
    always_comb begin
        alu_s = 32'd0;
        case (alu_fun_s)
            F_ADD:   alu_s = op_a_s + op_b_s;
            F_SUB:   alu_s = op_a_s - op_b_s;
            F_AND:   alu_s = op_a_s & op_b_s;
            F_OR:    alu_s = op_a_s | op_b_s;
            F_XOR:   alu_s = op_a_s ^ op_b_s;
            F_NOR:   alu_s = ~(op_a_s | op_b_s);
            F_PASS:  alu_s = op_a_s;
            F_SLL:   alu_s = op_b_s << op_a_s[4:0];
            F_SRL:   alu_s = op_b_s >> op_a_s[4:0];
            F_SRA:   alu_s = $signed(op_b_s) >>> op_a_s[4:0];
            F_EQ:    alu_s = {31'd0, (op_a_s == op_b_s)};
            F_NEQ:   alu_s = {31'd0, (op_a_s != op_b_s)};
            F_LT:    alu_s = {31'd0, lt_s};
            F_LEZ:   alu_s = {31'd0, ($signed(op_a_s) <= 32'sd0)};
            F_LTZ:   alu_s = {31'd0, op_a_s[31]};
            F_GTZ:   alu_s = {31'd0, ($signed(op_a_s) > 32'sd0)};
            default: alu_s = 32'd0;
        endcase
    end

    // Result select, destination register and next EX/MEM contents
    always_comb begin
        result_s = lu_op_s ? (lu_data_s & 32'hFFFF_0000) : alu_s;
        case (reg_dst_s)
            2'b00:   write_reg_s = rd_s;
            2'b01:   write_reg_s = rt_s;
            2'b10:   write_reg_s = 5'd31;
            2'b11:   write_reg_s = 5'd26;
            default: write_reg_s = 5'd0;
        endcase
        ex_mem_next_s = {reg_write_s, mem_to_reg_s, mem_read_s, mem_write_s,
                         pc_plus4_s, write_reg_s, fwd_rt_s, result_s};
    end

    // EX/MEM pipeline register, loads every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_mem_r <= 106'd0;
        end else begin
            ex_mem_r <= ex_mem_next_s;
        end
    end

    assign bus.EX_MEM        = ex_mem_r;
    assign bus.BranchTaken   = branch_s & alu_s[0];
    assign bus.branch_target = bus.ID_EX[119:88];
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected EX_MEM words are queued as each
// instruction is driven and compared one cycle later.
module tb_ex_stage;
    localparam logic [31:0] PC_DEF = 32'h0040_0100;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [105:0] exp_q[$];
    string        tag_q[$];
    logic [229:0] b;

    ex_if bus();
    ex_stage dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [105:0] got, input logic [105:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [105:0] em(input logic rw, input logic [1:0] m2r, input logic mr,
                                        input logic mw, input logic [31:0] pc4, input logic [4:0] wr,
                                        input logic [31:0] st, input logic [31:0] alu);
        return {rw, m2r, mr, mw, pc4, wr, st, alu};
    endfunction

    function automatic logic [229:0] mk(input logic [5:0] fun, input logic [31:0] rsd,
                                        input logic [31:0] rtd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd, input logic rw);
        logic [229:0] v;
        v = '0;
        v[31:0] = rsd; v[63:32] = rtd; v[68:64] = rs; v[73:69] = rt; v[78:74] = rd;
        v[85:80] = fun; v[122] = rw; v[189:158] = PC_DEF;
        return v;
    endfunction

    task automatic step(input string tag, input logic [229:0] id, input logic [105:0] exp_em,
                        input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd,
                        input logic chk_br, input logic exp_br, input logic [31:0] exp_tgt);
        @(negedge clk);
        bus.ID_EX = id;
        bus.MEM_WB_RegWrite = wbw;
        bus.MEM_WB_WriteReg = wbr;
        bus.MEM_WB_RegWriteData = wbd;
        exp_q.push_back(exp_em);
        tag_q.push_back(tag);
        if (chk_br) begin
            #1;
            check_eq({tag, "_br"}, {105'd0, bus.BranchTaken}, {105'd0, exp_br});
            check_eq({tag, "_tgt"}, {74'd0, bus.branch_target}, {74'd0, exp_tgt});
        end
    endtask

    // Pop one expected EX_MEM word per cycle once output is due
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            check_eq(tag_q.pop_front(), bus.EX_MEM, exp_q.pop_front());
        end
    end

    logic [5:0]  t_fun[17];
    logic [31:0] t_a[17], t_b[17], t_exp[17];
    logic        t_sign[17];

    initial begin
        t_fun[0]  = 6'b000001; t_a[0]  = 32'hF0F01234; t_b[0]  = 32'h0FF00003; t_exp[0]  = 32'hE1001231;
        t_fun[1]  = 6'b011000; t_a[1]  = 32'hF0F01234; t_b[1]  = 32'h0FF00003; t_exp[1]  = 32'h00F00000;
        t_fun[2]  = 6'b011110; t_a[2]  = 32'hF0F01234; t_b[2]  = 32'h0FF00003; t_exp[2]  = 32'hFFF01237;
        t_fun[3]  = 6'b010110; t_a[3]  = 32'hF0F01234; t_b[3]  = 32'h0FF00003; t_exp[3]  = 32'hFF001237;
        t_fun[4]  = 6'b010001; t_a[4]  = 32'hF0F01234; t_b[4]  = 32'h0FF00003; t_exp[4]  = 32'h000FEDC8;
        t_fun[5]  = 6'b011010; t_a[5]  = 32'hF0F01234; t_b[5]  = 32'h0FF00003; t_exp[5]  = 32'hF0F01234;
        t_fun[6]  = 6'b100000; t_a[6]  = 32'hF0F01234; t_b[6]  = 32'h0FF00003; t_exp[6]  = 32'h00300000;
        t_fun[7]  = 6'b100001; t_a[7]  = 32'hF0F01234; t_b[7]  = 32'h0FF00003; t_exp[7]  = 32'h000000FF;
        t_fun[8]  = 6'b110001; t_a[8]  = 32'hF0F01234; t_b[8]  = 32'h0FF00003; t_exp[8]  = 32'h00000001;
        t_fun[9]  = 6'b111101; t_a[9]  = 32'hF0F01234; t_b[9]  = 32'h0FF00003; t_exp[9]  = 32'h00000001;
        t_fun[10] = 6'b111011; t_a[10] = 32'hF0F01234; t_b[10] = 32'h0FF00003; t_exp[10] = 32'h00000001;
        t_fun[11] = 6'b111111; t_a[11] = 32'hF0F01234; t_b[11] = 32'h0FF00003; t_exp[11] = 32'h00000000;
        t_fun[12] = 6'b111110; t_a[12] = 32'hF0F01234; t_b[12] = 32'h0FF00003; t_exp[12] = 32'h00000000;
        t_fun[13] = 6'b110011; t_a[13] = 32'h00000007; t_b[13] = 32'h00000007; t_exp[13] = 32'h00000001;
        t_fun[14] = 6'b111111; t_a[14] = 32'h00000005; t_b[14] = 32'h00000000; t_exp[14] = 32'h00000001;
        t_fun[15] = 6'b111101; t_a[15] = 32'h00000000; t_b[15] = 32'h00000000; t_exp[15] = 32'h00000001;
        t_fun[16] = 6'b110101; t_a[16] = 32'h00000001; t_b[16] = 32'hFFFFFFFF; t_exp[16] = 32'h00000001;
        for (int i = 0; i < 17; i++) t_sign[i] = (i != 16);

        reset = 1'b1;
        bus.ID_EX = '0;
        bus.MEM_WB_RegWrite = 1'b0;
        bus.MEM_WB_WriteReg = 5'd0;
        bus.MEM_WB_RegWriteData = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_em", bus.EX_MEM, 106'd0);
        reset = 1'b0;

        b = mk(6'b000000, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 1'b1);
        step("add", b, em(1'b1, 2'b00, 1'b0, 1'b0, PC_DEF, 5'd3, 32'd7, 32'd12), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);

        // Asynchronous reset mid-cycle with a live ID_EX
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("arst_em", bus.EX_MEM, 106'd0);
        check_eq("arst_br", {105'd0, bus.BranchTaken}, 106'd0);
        @(negedge clk);
        reset = 1'b0;

        b = mk(6'b000000, 32'h11, 32'd0, 5'd0, 5'd0, 5'd8, 1'b1);
        step("fw_a", b, em(1'b1, 2'b00, 1'b0, 1'b0, PC_DEF, 5'd8, 32'd0, 32'h11), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        b = mk(6'b000001, 32'h55, 32'd0, 5'd8, 5'd0, 5'd9, 1'b1);
        step("fw_exmem", b, em(1'b1, 2'b00, 1'b0, 1'b0, PC_DEF, 5'd9, 32'd0, 32'h11), 1'b1, 5'd8, 32'h22, 1'b0, 1'b0, 32'd0);
        b = mk(6'b000000, 32'h33, 32'd0, 5'd0, 5'd0, 5'd8, 1'b0);
        step("fw_c", b, em(1'b0, 2'b00, 1'b0, 1'b0, PC_DEF, 5'd8, 32'd0, 32'h33), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        b = mk(6'b000001, 32'h55, 32'd0, 5'd8, 5'd0, 5'd9, 1'b1);
        step("fw_memwb", b, em(1'b1, 2'b00, 1'b0, 1'b0, PC_DEF, 5'd9, 32'd0, 32'h22), 1'b1, 5'd8, 32'h22, 1'b0, 1'b0, 32'd0);
        b = mk(6'b000000, 32'h44, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        step("fw_e", b, em(1'b1, 2'b00, 1'b0, 1'b0, PC_DEF, 5'd0, 32'd0, 32'h44), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        b = mk(6'b000001, 32'h66, 32'd0, 5'd0, 5'd0, 5'd10, 1'b1);
        step("fw_r0", b, em(1'b1, 2'b00, 1'b0, 1'b0, PC_DEF, 5'd10, 32'd0, 32'h66), 1'b1, 5'd0, 32'h77, 1'b0, 1'b0, 32'd0);

        b = mk(6'b110011, 32'd3, 32'd3, 5'd4, 5'd5, 5'd0, 1'b0);
        b[227] = 1'b1; b[119:88] = 32'h0040_0040;
        step("beq_t", b, em(1'b0, 2'b00, 1'b0, 1'b0, PC_DEF, 5'd0, 32'd3, 32'd1), 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'h0040_0040);
        b[63:32] = 32'd4;
        step("beq_nt", b, em(1'b0, 2'b00, 1'b0, 1'b0, PC_DEF, 5'd0, 32'd4, 32'd0), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'h0040_0040);

        b = mk(6'b110101, 32'hFFFF_FFFF, 32'd1, 5'd6, 5'd7, 5'd0, 1'b0);
        b[79] = 1'b1;
        step("lt_s", b, em(1'b0, 2'b00, 1'b0, 1'b0, PC_DEF, 5'd0, 32'd1, 32'd1), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        b[79] = 1'b0;
        step("lt_u", b, em(1'b0, 2'b00, 1'b0, 1'b0, PC_DEF, 5'd0, 32'd1, 32'd0), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        b = mk(6'b100011, 32'd0, 32'h8000_0000, 5'd0, 5'd7, 5'd0, 1'b0);
        b[87] = 1'b1; b[194:190] = 5'd4;
        step("sra", b, em(1'b0, 2'b00, 1'b0, 1'b0, PC_DEF, 5'd0, 32'h8000_0000, 32'hF800_0000), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);

        b = mk(6'b000000, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        b[229:228] = 2'b10; b[124:123] = 2'b10; b[189:158] = 32'h0040_0008;
        step("jal", b, em(1'b1, 2'b10, 1'b0, 1'b0, 32'h0040_0008, 5'd31, 32'd0, 32'd0), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        b = mk(6'b000000, 32'hBAD, 32'd0, 5'd31, 5'd0, 5'd11, 1'b1);
        step("fw_link", b, em(1'b1, 2'b00, 1'b0, 1'b0, PC_DEF, 5'd11, 32'd0, 32'h0040_0008), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        b = mk(6'b000000, 32'd0, 32'h5555, 5'd0, 5'd12, 5'd0, 1'b1);
        b[229:228] = 2'b01; b[157] = 1'b1; b[156:125] = 32'h1234_5678;
        step("lui", b, em(1'b1, 2'b00, 1'b0, 1'b0, PC_DEF, 5'd12, 32'h5555, 32'h1234_0000), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);

        b = mk(6'b000000, 32'h100, 32'h1111, 5'd13, 5'd14, 5'd0, 1'b0);
        b[86] = 1'b1; b[226:195] = 32'd4; b[120] = 1'b1;
        step("sw", b, em(1'b0, 2'b00, 1'b0, 1'b1, PC_DEF, 5'd0, 32'hDEAD_BEEF, 32'h104), 1'b1, 5'd14, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < 17; i++) begin
            b = mk(t_fun[i], t_a[i], t_b[i], 5'd0, 5'd0, 5'd0, 1'b0);
            b[79] = t_sign[i];
            step($sformatf("alu%0d", i), b, em(1'b0, 2'b00, 1'b0, 1'b0, PC_DEF, 5'd0, t_b[i], t_exp[i]),
                 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        end

        step("bubble", 230'd0, 106'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        check_eq("drain", {74'd0, 32'(exp_q.size())}, 106'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
